// File: rtl/green_mask_pkg.sv
// rtl/green_mask_pkg.sv - image geometry, colour thresholds and FSM states for the green mask builder
package green_mask_pkg;
   localparam int HEIGHT     = 20;
   localparam int WIDTH      = 30;
   localparam int DEPTH      = 3;
   localparam int LO0        = 18;
   localparam int LO1        = 25;
   localparam int LO2        = 25;
   localparam int HI0        = 43;
   localparam int HI1        = 255;
   localparam int HI2        = 255;
   localparam int NUM_BYTES  = HEIGHT * WIDTH * DEPTH;
   localparam int NUM_PIXELS = HEIGHT * WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/green_mask_builder_channel_range_check.sv
// rtl/green_mask_builder_channel_range_check.sv - per-channel inclusive range compare with held channel 0/1 flags
module channel_range_check #(
   parameter int LO0 = 18,
   parameter int LO1 = 25,
   parameter int LO2 = 25,
   parameter int HI0 = 43,
   parameter int HI1 = 255,
   parameter int HI2 = 255
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_clear,
   input  logic       i_valid,
   input  logic [1:0] i_chan,
   input  logic [7:0] i_data,
   output logic       o_pixel_ok
);
   logic [7:0] w_lo;
   logic [7:0] w_hi;
   logic       w_in_range;
   logic       r_flag0;
   logic       r_flag1;

   always_comb begin
      w_lo = 8'(LO2);
      w_hi = 8'(HI2);
      case (i_chan)
         2'd0:    begin w_lo = 8'(LO0); w_hi = 8'(HI0); end
         2'd1:    begin w_lo = 8'(LO1); w_hi = 8'(HI1); end
         default: begin w_lo = 8'(LO2); w_hi = 8'(HI2); end
      endcase
      w_in_range = (i_data >= w_lo) && (i_data <= w_hi);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_flag0 <= 1'b0;
         r_flag1 <= 1'b0;
      end else if (i_clear) begin
         r_flag0 <= 1'b0;
         r_flag1 <= 1'b0;
      end else if (i_valid) begin
         if (i_chan == 2'd0) r_flag0 <= w_in_range;
         if (i_chan == 2'd1) r_flag1 <= w_in_range;
      end
   end

   // Pixel verdict is only meaningful on the cycle its channel-2 byte is on the bus.
   assign o_pixel_ok = i_valid && (i_chan == 2'd2) && r_flag0 && r_flag1 && w_in_range;
endmodule

// File: rtl/green_mask_builder.sv
// rtl/green_mask_builder.sv - streams an RGB image from byte memory and builds a binary in-range pixel mask
module green_mask_builder #(
   parameter int HEIGHT = green_mask_pkg::HEIGHT,
   parameter int WIDTH  = green_mask_pkg::WIDTH,
   parameter int DEPTH  = green_mask_pkg::DEPTH,
   parameter int LO0    = green_mask_pkg::LO0,
   parameter int LO1    = green_mask_pkg::LO1,
   parameter int LO2    = green_mask_pkg::LO2,
   parameter int HI0    = green_mask_pkg::HI0,
   parameter int HI1    = green_mask_pkg::HI1,
   parameter int HI2    = green_mask_pkg::HI2
) (
   input  logic                      fpga_clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      rd_en,
   output logic [10:0]               rd_addr,
   input  logic [7:0]                rd_data,
   output logic                      busy,
   output logic                      done,
   output logic [HEIGHT*WIDTH-1:0]   mask,
   output logic [9:0]                pixel_count
);
   import green_mask_pkg::*;

   localparam int NB = HEIGHT * WIDTH * DEPTH;
   localparam int NP = HEIGHT * WIDTH;

   state_t            r_state;
   state_t            w_next;
   logic              w_start_build;
   logic              w_last_addr;
   logic              w_pixel_ok;
   logic [10:0]       r_addr;
   logic [1:0]        r_chan;
   logic [9:0]        r_pix;
   logic              r_d_vld;
   logic [1:0]        r_d_chan;
   logic [9:0]        r_d_pix;
   logic [NP-1:0]     r_mask;
   logic [9:0]        r_count;

   assign w_start_build = (r_state == IDLE) && start;
   assign w_last_addr   = (r_addr == 11'(NB - 1));

   always_ff @(posedge fpga_clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = READ;
         READ:    if (w_last_addr) w_next = DRAIN;
         DRAIN:   w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      rd_en = (r_state == READ);
      busy  = (r_state == READ) || (r_state == DRAIN);
      done  = (r_state == DONE);
   end

   // Address, channel and pixel counters advance together so no divide is needed.
   always_ff @(posedge fpga_clk or posedge rst) begin
      if (rst) begin
         r_addr <= '0;
         r_chan <= '0;
         r_pix  <= '0;
      end else if (w_start_build) begin
         r_addr <= '0;
         r_chan <= '0;
         r_pix  <= '0;
      end else if ((r_state == READ) && !w_last_addr) begin
         r_addr <= r_addr + 11'd1;
         if (r_chan == 2'(DEPTH - 1)) begin
            r_chan <= '0;
            r_pix  <= r_pix + 10'd1;
         end else begin
            r_chan <= r_chan + 2'd1;
         end
      end
   end

   always_ff @(posedge fpga_clk or posedge rst) begin
      if (rst) begin
         r_d_vld  <= 1'b0;
         r_d_chan <= '0;
         r_d_pix  <= '0;
      end else begin
         r_d_vld  <= (r_state == READ);
         r_d_chan <= r_chan;
         r_d_pix  <= r_pix;
      end
   end

   channel_range_check #(
      .LO0(LO0), .LO1(LO1), .LO2(LO2),
      .HI0(HI0), .HI1(HI1), .HI2(HI2)
   ) u_range (
      .i_clk      (fpga_clk),
      .i_rst      (rst),
      .i_clear    (w_start_build),
      .i_valid    (r_d_vld),
      .i_chan     (r_d_chan),
      .i_data     (rd_data),
      .o_pixel_ok (w_pixel_ok)
   );

   always_ff @(posedge fpga_clk or posedge rst) begin
      if (rst) begin
         r_mask  <= '0;
         r_count <= '0;
      end else if (w_start_build) begin
         r_mask  <= '0;
         r_count <= '0;
      end else if (r_d_vld && (r_d_chan == 2'(DEPTH - 1))) begin
         r_mask[r_d_pix] <= w_pixel_ok;
         if (w_pixel_ok) r_count <= r_count + 10'd1;
      end
   end

   assign rd_addr     = r_addr;
   assign mask        = r_mask;
   assign pixel_count = r_count;
endmodule

// File: tb/tb_green_mask_builder.sv
// tb/tb_green_mask_builder.sv - randomized self-checking bench for green_mask_builder against a behavioural model
module tb_green_mask_builder;
   logic          fpga_clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          rd_en;
   logic [10:0]   rd_addr;
   logic [7:0]    rd_data = 8'd0;
   logic          busy;
   logic          done;
   logic [599:0]  mask;
   logic [9:0]    pixel_count;

   logic [7:0]    mem [0:1799];
   logic [599:0]  exp_mask;
   int            exp_count;
   int            lo [3] = '{18, 25, 25};
   int            hi [3] = '{43, 255, 255};
   int            checks = 0;
   int            errors = 0;

   green_mask_builder dut (
      .fpga_clk    (fpga_clk),
      .rst         (rst),
      .start       (start),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .busy        (busy),
      .done        (done),
      .mask        (mask),
      .pixel_count (pixel_count)
   );

   always #5 fpga_clk = ~fpga_clk;

   // Memory answers one cycle later; garbage when not strobed.
   always @(posedge fpga_clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
      else       rd_data <= 8'($urandom);
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_mask(input string name);
      checks++;
      if (mask !== exp_mask) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, mask, exp_mask);
      end
   endtask

   task automatic set_pixel(input int p, input int c0, input int c1, input int c2);
      mem[3*p]   = 8'(c0);
      mem[3*p+1] = 8'(c1);
      mem[3*p+2] = 8'(c2);
   endtask

   task automatic compute_model();
      exp_mask  = '0;
      exp_count = 0;
      for (int p = 0; p < 600; p++) begin
         bit ok = 1'b1;
         for (int c = 0; c < 3; c++)
            if (int'(mem[3*p+c]) < lo[c] || int'(mem[3*p+c]) > hi[c]) ok = 1'b0;
         exp_mask[p] = ok;
         if (ok) exp_count++;
      end
   endtask

   task automatic fill_random();
      for (int p = 0; p < 600; p++)
         for (int c = 0; c < 3; c++) begin
            int sel = $urandom_range(0, 7);
            int v;
            case (sel)
               0: v = lo[c] - 1;
               1: v = lo[c];
               2: v = hi[c];
               3: v = hi[c] + 1;
               4: v = $urandom_range(0, 255);
               default: v = (lo[c] + hi[c]) / 2;
            endcase
            mem[3*p+c] = 8'(v);
         end
   endtask

   // Start a build and check the full cycle-by-cycle schedule, then the final mask and count.
   task automatic run_build(input string tag, input int start_again_cyc, input int pin_count);
      compute_model();
      @(negedge fpga_clk);
      start = 1'b1;
      for (int c = 1; c <= 1806; c++) begin
         @(negedge fpga_clk);
         if (c == start_again_cyc)  start = 1'b1;
         else                       start = 1'b0;
         chk({tag, " busy"}, busy, (c <= 1801) ? 1 : 0);
         chk({tag, " done"}, done, (c == 1802) ? 1 : 0);
         chk({tag, " rd_en"}, rd_en, (c <= 1800) ? 1 : 0);
         chk({tag, " rd_addr"}, rd_addr, (c <= 1800) ? c - 1 : 1799);
      end
      chk_mask({tag, " mask"});
      chk({tag, " pixel_count"}, pixel_count, exp_count);
      if (pin_count >= 0) chk({tag, " pixel_count literal"}, pixel_count, pin_count);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " rd_en"}, rd_en, 0);
      chk({tag, " rd_addr"}, rd_addr, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " mask"}, (mask == '0) ? 1 : 0, 1);
      chk({tag, " pixel_count"}, pixel_count, 0);
   endtask

   initial begin
      #1 rst = 1'b1;
      #2 chk_reset_vals("reset");
      repeat (3) @(posedge fpga_clk);
      @(negedge fpga_clk) rst = 1'b0;
      #1 chk_reset_vals("post reset");

      for (int p = 0; p < 600; p++) set_pixel(p, 30, 100, 100);
      run_build("all green", -1, 600);

      for (int p = 0; p < 600; p++)
         if (p % 2 == 0) set_pixel(p, 17, 100, 100);
         else            set_pixel(p, 44, 100, 100);
      run_build("outside edges", -1, 0);

      for (int p = 0; p < 600; p++)
         if (p % 2 == 0) set_pixel(p, 18, 25, 25);
         else            set_pixel(p, 43, 255, 255);
      run_build("inclusive edges", -1, 600);

      for (int p = 0; p < 600; p++) set_pixel(p, 0, 0, 0);
      set_pixel(0, 30, 100, 100);
      set_pixel(599, 30, 100, 100);
      run_build("corners", -1, 2);
      chk("corners bit0", mask[0], 1);
      chk("corners bit599", mask[599], 1);
      chk("corners bit1", mask[1], 0);

      for (int k = 0; k < 3; k++) begin
         fill_random();
         run_build("random", (k == 1) ? 500 : -1, -1);
      end

      // Abort a build with reset at cycle 900.
      fill_random();
      @(negedge fpga_clk) start = 1'b1;
      @(negedge fpga_clk) start = 1'b0;
      repeat (899) @(negedge fpga_clk);
      chk("abort busy before", busy, 1);
      #2 rst = 1'b1;
      #1 chk_reset_vals("abort reset");
      @(negedge fpga_clk) rst = 1'b0;
      begin
         int done_seen = 0;
         int busy_seen = 0;
         for (int c = 0; c < 2000; c++) begin
            @(negedge fpga_clk);
            if (done) done_seen++;
            if (busy || rd_en) busy_seen++;
         end
         chk("abort no done", done_seen, 0);
         chk("abort stays idle", busy_seen, 0);
      end
      run_build("after abort", -1, -1);

      fill_random();
      run_build("final random", -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/green_mask_builder.md
GREEN_MASK_BUILDER -- requirements
Module: green_mask_builder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- HEIGHT, 20: image rows.
- WIDTH, 30: image columns.
- DEPTH, 3: channel bytes per pixel.
- LO0/LO1/LO2, 18/25/25: inclusive lower bounds for channels 0/1/2.
- HI0/HI1/HI2, 43/255/255: inclusive upper bounds for channels 0/1/2.

REQ-002 Ports (name, direction, width, meaning), one per line:
- fpga_clk, in, 1: sole clock, rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- start, in, 1: request one mask build; sampled on the clock.
- rd_en, out, 1: image-memory read strobe.
- rd_addr, out, 11: image byte address.
- rd_data, in, 8: byte read back, valid exactly one cycle after its rd_en/rd_addr.
- busy, out, 1: build in progress.
- done, out, 1: one-cycle pulse when the mask is complete.
- mask, out, HEIGHT*WIDTH: binary mask; bit h*WIDTH+w is pixel (h,w).
- pixel_count, out, 10: number of set mask bits.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, READ, DRAIN, DONE.
REQ-004 In IDLE, start=1 SHALL clear mask and pixel_count, zero the address counter, and move to READ.
REQ-005 In READ, the block SHALL drive rd_en=1 with rd_addr = 0,1,...,HEIGHT*WIDTH*DEPTH-1, one address per cycle with no gaps; after issuing address 1799 it SHALL move to DRAIN.
REQ-006 Byte address 3p+c SHALL be treated as channel c of pixel p, with p = h*WIDTH+w.
REQ-007 Each returning byte SHALL be compared inclusively against LOc/HIc. Per-pixel in-range flags SHALL be held in registers until channel 2 arrives.
REQ-008 On the cycle channel 2 of pixel p returns, mask[p] SHALL be set to AND(flag0, flag1, in-range of the channel-2 byte). If that bit is 1, pixel_count SHALL increment by 1.
REQ-009 DRAIN SHALL last one cycle, to absorb the last byte, then move to DONE. DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-010 Latency: with start sampled at edge 0, done SHALL be high in cycle 1802 and busy high in cycles 1..1801.
REQ-011 busy SHALL be 1 in READ and DRAIN, and 0 in IDLE and DONE. rd_en SHALL be 0 outside READ.
REQ-012 start SHALL be ignored outside IDLE; a start held high through DONE SHALL begin a new build from the following IDLE cycle.
REQ-013 mask and pixel_count SHALL hold their final values from done until the next accepted start.
REQ-014 pixel_count SHALL be 10-bit unsigned; its maximum value is 600, so it never wraps.
REQ-015 rd_addr SHALL hold its last value when rd_en=0.

Reset
REQ-016 While rst=1, regardless of the clock: state=IDLE, rd_en=0, rd_addr=0, busy=0, done=0, mask=0, pixel_count=0, flags=0.
REQ-017 A reset asserted mid-build SHALL abort the build with no done pulse; the next build requires a new start.

Structure
REQ-018 The shared package green_mask_pkg SHALL hold HEIGHT, WIDTH, DEPTH, the six threshold constants, the derived NUM_BYTES=1800 and NUM_PIXELS=600, and the state enum.
REQ-019 The per-channel comparator plus flag register SHALL be one sub-module, channel_range_check, instantiated once.

Verification
REQ-020 All 1800 bytes = {30,100,100} per pixel, then start -> done at cycle 1802, mask all ones, pixel_count=600.
REQ-021 All pixels {17,100,100} and {44,100,100} alternately -> mask=0, pixel_count=0 (exclusive edges rejected); repeat with {18,25,25}/{43,255,255} -> all ones (inclusive edges accepted).
REQ-022 Only pixel 0 and pixel 599 green, all others {0,0,0} -> mask bits 0 and 599 set, pixel_count=2.
REQ-023 rst pulsed at cycle 900 of a build -> outputs return to reset values, no done pulse; a following start produces a correct mask.
REQ-024 start pulsed at cycle 500 of a build -> ignored; exactly one done pulse, at cycle 1802.
REQ-025 rd_addr monitor confirms a strictly sequential sequence 0..1799 with no duplicates and rd_en low in DRAIN, DONE and IDLE.
